uart_rx_fsm: RTL

//  Frame controller for the UART receiver. Detects the start edge and tracks edge/bit position within the frame.

---
 rtl/uart_rx_fsm_pkg.sv | 23 ++
 rtl/uart_rx_fsm_if.sv | 38 +++
 rtl/uart_rx_fsm_edge_bit_counter.sv | 40 ++++
 rtl/uart_rx_fsm.sv | 100 ++++++++++
 4 files changed

// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART RX frame controller: frame geometry,
// counter widths, FSM state encoding and the prescale clamp helper.
package uart_rx_fsm_pkg;

    localparam int unsigned DATA_WIDTH     = 8;
    localparam int unsigned PRESCALE_WIDTH = 6;
    localparam int unsigned BIT_CNT_WIDTH  = 4;
    localparam int unsigned PRESCALE_MIN   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Ratios below the minimum cannot place the check edge inside the bit.
    function automatic logic [PRESCALE_WIDTH-1:0] clamp_prescale(input logic [PRESCALE_WIDTH-1:0] p);
        return (p < PRESCALE_WIDTH'(PRESCALE_MIN)) ? PRESCALE_WIDTH'(PRESCALE_MIN) : p;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Bundle between the RX frame controller and the RX datapath.
//   Line/config : RX_IN, Prescale, PAR_EN
//   Checker flags: strt_glitch, par_err, stp_err
//   Controls    : dat_samp_en, edge_cnt, bit_cnt, strt/par/stp_chk_en, deser_en
//   Results     : data_valid, frame_err
// master = frame controller, slave = datapath side.
interface uart_rx_fsm_if;
    import uart_rx_fsm_pkg::*;

    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      PAR_EN;
    logic                      strt_glitch;
    logic                      par_err;
    logic                      stp_err;
    logic                      dat_samp_en;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      strt_chk_en;
    logic                      par_chk_en;
    logic                      stp_chk_en;
    logic                      deser_en;
    logic                      data_valid;
    logic                      frame_err;

    modport master (
        input  RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        output dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en,
               stp_chk_en, deser_en, data_valid, frame_err
    );

    modport slave (
        output RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
        input  dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en,
               stp_chk_en, deser_en, data_valid, frame_err
    );

endinterface

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and frame bit counter.
//   CLK, RST : clock, synchronous active-high reset
//   enable   : count edges (frame in progress)
//   clear    : force both counters to 0 on the next edge
//   presc_q  : latched oversampling ratio for this frame
//   edge_cnt : 0..presc_q-1 within the current bit
//   bit_cnt  : bit index within the frame
//   wrap     : high on the last edge of a bit
module uart_rx_fsm_edge_bit_counter
    import uart_rx_fsm_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] presc_q,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      wrap
);

    logic [PRESCALE_WIDTH-1:0] last;

    assign last = presc_q - PRESCALE_WIDTH'(1);
    assign wrap = enable && (edge_cnt == last);

    // Edge count wraps last->0 and advances the bit index on the wrap.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_WIDTH'(1);
        end else if (enable) begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame controller: detects the start edge, sequences
// START/DATA/PARITY/STOP, strobes the datapath checkers and reports
// each frame with a one-cycle data_valid or frame_err.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : uart_rx_fsm_if.master (line, config, checker flags, controls)
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    uart_rx_fsm_if.master bus
);

    rx_state_e                 state;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [PRESCALE_WIDTH-1:0] chk;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      perr_q;
    logic                      data_valid_q;
    logic                      frame_err_q;
    logic                      wrap;
    logic                      enable;
    logic                      clear;
    logic                      at_chk;

    // Sampled bit is valid two edges past mid-bit.
    assign chk    = (presc_q >> 1) + PRESCALE_WIDTH'(2);
    assign at_chk = (edge_cnt == chk);
    assign enable = (state != IDLE);
    // Counters read 0 throughout IDLE, including the first IDLE cycle.
    assign clear  = (state == IDLE)
                 || (wrap && (((state == START) && bus.strt_glitch) || (state == STOP)));

    uart_rx_fsm_edge_bit_counter u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (enable),
        .clear    (clear),
        .presc_q  (presc_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .wrap     (wrap)
    );

    // Frame sequencing; checker flags are only consulted on the wrap edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            presc_q      <= PRESCALE_WIDTH'(PRESCALE_MIN);
            perr_q       <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.RX_IN) begin
                        state   <= START;
                        presc_q <= clamp_prescale(bus.Prescale);
                        perr_q  <= 1'b0;
                    end
                end
                START: begin
                    if (wrap) state <= bus.strt_glitch ? IDLE : DATA;
                end
                DATA: begin
                    if (wrap && (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH)))
                        state <= bus.PAR_EN ? PARITY : STOP;
                end
                PARITY: begin
                    if (wrap) begin
                        perr_q <= bus.par_err;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        if (!perr_q && !bus.stp_err) data_valid_q <= 1'b1;
                        else                         frame_err_q  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dat_samp_en = (state != IDLE);
    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.strt_chk_en = (state == START)  && at_chk;
    assign bus.deser_en    = (state == DATA)   && at_chk;
    assign bus.par_chk_en  = (state == PARITY) && at_chk;
    assign bus.stp_chk_en  = (state == STOP)   && at_chk;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_err   = frame_err_q;

endmodule
